// File: rtl/bubsysrom_pkg.sv
// Shared constants for the BubSysROM colour stage: palette geometry, field
// positions inside a palette word and the pixel pipeline latency.
package bubsysrom_pkg;

  localparam int unsigned PAL_AW  = 11;
  localparam int unsigned PAL_DW  = 16;
  localparam int unsigned CPU_AW  = 15;
  localparam int unsigned COLW    = 5;

  localparam int unsigned R_LSB   = 0;
  localparam int unsigned G_LSB   = 5;
  localparam int unsigned B_LSB   = 10;

  localparam int unsigned PAL_LAT = 2;

endpackage

// File: rtl/bubsysrom_palette_if.sv
// 68000 bus slice seen by the palette RAM (chip select, strobes, data).
interface bubsysrom_palette_if;
  import bubsysrom_pkg::*;

  logic [CPU_AW-1:0] i_CPU_ADDR;
  logic [PAL_DW-1:0] i_CPU_DIN;
  logic [PAL_DW-1:0] o_CPU_DOUT;
  logic              i_CPU_RW;
  logic              i_CPU_UDS_n;
  logic              i_CPU_LDS_n;
  logic              i_PALCS_n;

  modport master (
    output i_CPU_ADDR, i_CPU_DIN, i_CPU_RW, i_CPU_UDS_n, i_CPU_LDS_n, i_PALCS_n,
    input  o_CPU_DOUT
  );

  modport slave (
    input  i_CPU_ADDR, i_CPU_DIN, i_CPU_RW, i_CPU_UDS_n, i_CPU_LDS_n, i_PALCS_n,
    output o_CPU_DOUT
  );

endinterface

// File: rtl/bubsysrom_palram.sv
// True dual-port palette RAM: port A CPU (byte-enable write, registered read),
// port B video (read only, registered read). Both ports read-before-write.
module bubsysrom_palram
  import bubsysrom_pkg::*;
#(
  parameter int unsigned AW = bubsysrom_pkg::PAL_AW
) (
  input  logic              clk,
  input  logic [AW-1:0]     a_addr,
  input  logic [PAL_DW-1:0] a_din,
  input  logic [1:0]        a_we,
  output logic [PAL_DW-1:0] a_dout,
  input  logic              b_en,
  input  logic [AW-1:0]     b_addr,
  output logic [PAL_DW-1:0] b_dout
);

  logic [PAL_DW-1:0] mem [0:(1<<AW)-1];

  always_ff @(posedge clk) begin
    a_dout <= mem[a_addr];
    if (b_en) begin
      b_dout <= mem[b_addr];
    end
    if (a_we[1]) begin
      mem[a_addr][PAL_DW-1:PAL_DW/2] <= a_din[PAL_DW-1:PAL_DW/2];
    end
    if (a_we[0]) begin
      mem[a_addr][PAL_DW/2-1:0] <= a_din[PAL_DW/2-1:0];
    end
  end

endmodule

// File: rtl/bubsysrom_palette.sv
// Palette stage: turns the video colour code into 5:5:5 RGB and gives the
// 68000 read/write access to the palette RAM.
module bubsysrom_palette
  import bubsysrom_pkg::*;
#(
  parameter int unsigned PAL_AW      = bubsysrom_pkg::PAL_AW,
  parameter int unsigned COLW        = bubsysrom_pkg::COLW,
  parameter bit          BLANK_BLACK = 1'b1
) (
  input  logic              i_EMU_MCLK,
  input  logic              i_EMU_RST,
  input  logic              i_EMU_CLK6MPCEN_n,
  bubsysrom_palette_if.slave cpu,
  input  logic [PAL_AW-1:0] i_CD,
  input  logic              i_VBLANK_n,
  input  logic              i_HBLANK_n,
  input  logic              i_SYNC_n,
  output logic [COLW-1:0]   o_R,
  output logic [COLW-1:0]   o_G,
  output logic [COLW-1:0]   o_B,
  output logic              o_BLANK_n,
  output logic              o_SYNC_n
);

  logic [PAL_AW-1:0] cpu_idx;
  logic              acc_act;
  logic              acc_prev;
  logic              commit;
  logic [1:0]        we;
  logic              cs_q;
  logic              pen;
  logic [PAL_DW-1:0] ram_a_q;
  logic [PAL_DW-1:0] ram_b_q;
  logic              blank_s1;
  logic              sync_s1;
  logic              unused_addr_hi;

  // Upper address bits are not decoded, so the palette aliases.
  assign cpu_idx        = cpu.i_CPU_ADDR[PAL_AW-1:0];
  assign unused_addr_hi = ^cpu.i_CPU_ADDR[CPU_AW-1:PAL_AW];

  assign pen     = ~i_EMU_CLK6MPCEN_n;
  assign acc_act = ~cpu.i_PALCS_n & (~cpu.i_CPU_UDS_n | ~cpu.i_CPU_LDS_n);
  assign commit  = acc_act & ~acc_prev & ~cpu.i_CPU_RW & ~i_EMU_RST;
  assign we      = {commit & ~cpu.i_CPU_UDS_n, commit & ~cpu.i_CPU_LDS_n};

  // The RAM's registered video read is stage 1 (it latches i_CD); the
  // flags are registered alongside it so both reach stage 2 together.
  bubsysrom_palram #(.AW(PAL_AW)) u_palram (
    .clk    (i_EMU_MCLK),
    .a_addr (cpu_idx),
    .a_din  (cpu.i_CPU_DIN),
    .a_we   (we),
    .a_dout (ram_a_q),
    .b_en   (pen),
    .b_addr (i_CD),
    .b_dout (ram_b_q)
  );

  always_ff @(posedge i_EMU_MCLK) begin
    if (i_EMU_RST) begin
      acc_prev  <= 1'b0;
      cs_q      <= 1'b0;
      blank_s1  <= 1'b0;
      sync_s1   <= 1'b1;
      o_R       <= '0;
      o_G       <= '0;
      o_B       <= '0;
      o_BLANK_n <= 1'b0;
      o_SYNC_n  <= 1'b1;
    end else begin
      acc_prev <= acc_act;
      cs_q     <= ~cpu.i_PALCS_n;
      if (pen) begin
        blank_s1  <= i_VBLANK_n & i_HBLANK_n;
        sync_s1   <= i_SYNC_n;
        o_BLANK_n <= blank_s1;
        o_SYNC_n  <= sync_s1;
        if (BLANK_BLACK && !blank_s1) begin
          o_R <= '0;
          o_G <= '0;
          o_B <= '0;
        end else begin
          o_R <= ram_b_q[R_LSB +: COLW];
          o_G <= ram_b_q[G_LSB +: COLW];
          o_B <= ram_b_q[B_LSB +: COLW];
        end
      end
    end
  end

  assign cpu.o_CPU_DOUT = cs_q ? ram_a_q : '0;

endmodule
